// File: rtl/alu_arbiter.sv
// alu_arbiter -- two-requester round-robin front end for one shared ALU.
//
// Accepts one operation at a time from requester 0 or 1. It latches the
// operands and drives them to an external combinational ALU, waits out the
// execute phase (1 cycle, or MUL_CYCLES for multiply), and then holds the
// result until the consumer takes it.
//
// Ports
//   clock, reset             clock; synchronous active-low reset
//   req_valid[1:0]           per-requester request strobe
//   req_ready[1:0]           per-requester accept (one-hot or zero)
//   req{0,1}_a/_b/_op/_unsig per-requester operands and control
//   alu_a/_b/_op/_unsig      latched operation driven to the shared ALU
//   alu_out, alu_overflow    combinational ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_data/_overflow/_id   captured result and issuing requester
//   ovf_count[7:0]           saturating count of overflowing completions
module alu_arbiter #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  input  logic        req0_unsig,
  input  logic        req1_unsig,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_unsig,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_overflow,
  output logic        rsp_id,
  output logic [7:0]  ovf_count
);

  generate
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
      $error("alu_arbiter: MUL_CYCLES must be within 1..15");
    end
  endgenerate

  localparam logic [2:0] OP_MUL   = 3'b111;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  // Requester inputs packed so the granted one is picked by a single index.
  logic [1:0][31:0] in_a, in_b;
  logic [1:0][2:0]  in_op;
  logic [1:0]       in_unsig;

  assign in_a     = {req1_a, req0_a};
  assign in_b     = {req1_b, req0_b};
  assign in_op    = {req1_op, req0_op};
  assign in_unsig = {req1_unsig, req0_unsig};

  // Latched operation and arbitration state
  logic [31:0] lat_a, lat_b;
  logic [2:0]  lat_op;
  logic        lat_unsig;
  logic        lat_id;
  logic        last_grant;   // requester granted most recently
  logic [3:0]  exec_cnt;     // remaining EXEC cycles after the current one

  logic [1:0]  grant;
  logic        sel;
  logic        hs;           // request handshake this cycle
  logic        exec_last;
  logic        rsp_exit;     // response handshake this cycle

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign sel       = grant[1];
  assign hs        = (state == IDLE) && (grant != 2'b00) && reset;
  assign exec_last = (exec_cnt == 4'd0);
  assign rsp_exit  = (state == RESP) && rsp_ready && reset;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    if (exec_last) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; both strobes are forced low while reset is held so an aborted
  // operation never looks live to either side.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    if (reset) begin
      req_ready = (state == IDLE) ? grant : 2'b00;
      rsp_valid = (state == RESP);
    end
  end

  // Operand latch, arbitration pointer and execute timer
  always_ff @(posedge clock) begin
    if (!reset) begin
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_unsig  <= 1'b0;
      lat_id     <= 1'b0;
      last_grant <= 1'b1;   // requester 0 wins the first tie
      exec_cnt   <= '0;
    end else if (hs) begin
      lat_a      <= in_a[sel];
      lat_b      <= in_b[sel];
      lat_op     <= in_op[sel];
      lat_unsig  <= in_unsig[sel];
      lat_id     <= sel;
      last_grant <= sel;
      exec_cnt   <= (in_op[sel] == OP_MUL) ? MUL_LOAD : 4'd0;
    end else if (state == EXEC && !exec_last) begin
      exec_cnt   <= exec_cnt - 4'd1;
    end
  end

  // Result capture on the final EXEC cycle; held through RESP.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
    end else if (state == EXEC && exec_last) begin
      rsp_data     <= alu_out;
      rsp_overflow <= alu_overflow;
    end
  end

  // Overflow counter advances only when an overflowing result is consumed.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ovf_count <= '0;
    end else if (rsp_exit && rsp_overflow && ovf_count != 8'hFF) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end

  assign alu_a     = lat_a;
  assign alu_b     = lat_b;
  assign alu_op    = lat_op;
  assign alu_unsig = lat_unsig;
  assign rsp_id    = lat_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter -- directed stimulus with a response scoreboard for alu_arbiter.
// The bench supplies the shared ALU: 010 add, 111 multiply, anything else subtract.
module tb_alu_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_unsig = 1'b0, req1_unsig = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_unsig;
  logic [31:0] alu_out;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_overflow;
  logic        rsp_id;
  logic [7:0]  ovf_count;

  alu_arbiter #(.MUL_CYCLES(3)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_unsig(req0_unsig), .req1_unsig(req1_unsig),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .rsp_id(rsp_id),
    .ovf_count(ovf_count)
  );

  always #5 clock = ~clock;

  // Shared ALU model
  logic [32:0] sum33;
  logic [31:0] diff;
  logic [63:0] pu, ps;
  always_comb begin
    sum33        = {1'b0, alu_a} + {1'b0, alu_b};
    diff         = alu_a - alu_b;
    pu           = {32'd0, alu_a} * {32'd0, alu_b};
    ps           = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    alu_out      = diff;
    alu_overflow = alu_unsig ? (alu_a < alu_b)
                             : (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
    case (alu_op)
      3'b010: begin
        alu_out      = sum33[31:0];
        alu_overflow = alu_unsig ? sum33[32]
                                 : (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
      end
      3'b111: begin
        alu_out      = pu[31:0];
        alu_overflow = alu_unsig ? (pu[63:32] != 32'd0) : (ps[63:32] != {32{ps[31]}});
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        id;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: one pop per consumed response.
  always @(negedge clock) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=data %h id %0d expected=no response", rsp_data, rsp_id);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic unsig);
    if (r == 0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_unsig = unsig;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_unsig = unsig;
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE. lat = execute
  // cycles; rsp_valid is first seen on negedge lat+1 after the handshake.
  task automatic run_op(input logic [1:0] v, input logic [1:0] g, input logic [31:0] d,
                        input logic o, input int lat, input int hold, input bit keep);
    exp_t e;
    int n;
    bit seen;
    req_valid = v;
    rsp_ready = (hold == 0);
    @(negedge clock);
    chk("req_ready_grant", 32'(req_ready), 32'(g));
    e.data = d; e.ovf = o; e.id = g[1];
    q.push_back(e);
    @(posedge clock); #1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      seen = rsp_valid;
    end
    chk("rsp_latency", 32'(n), 32'(lat + 1));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clock);
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        chk("hold_data", rsp_data, d);
        chk("hold_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clock); #1;
      rsp_ready = 1'b1;
    end
    @(posedge clock); #1;
    if (!keep) req_valid = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_valid = 2'b00;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    // Reset state; requests during reset must not be accepted.
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid = 2'b00;

    // Tie after reset goes to requester 0: 5+3
    set_req(0, 32'd5, 32'd3, 3'b010, 1'b0);
    set_req(1, 32'd10, 32'd20, 3'b010, 1'b0);
    run_op(2'b11, 2'b01, 32'd8, 1'b0, 1, 0, 0);

    // Round-robin with both held valid
    do_reset();
    run_op(2'b11, 2'b01, 32'd8,  1'b0, 1, 0, 1);
    run_op(2'b11, 2'b10, 32'd30, 1'b0, 1, 0, 1);
    run_op(2'b11, 2'b01, 32'd8,  1'b0, 1, 0, 1);
    run_op(2'b11, 2'b10, 32'd30, 1'b0, 1, 0, 0);

    // Signed add overflow from requester 1
    begin
      logic [7:0] c;
      c = ovf_count;
      set_req(1, 32'h7FFF_FFFF, 32'd1, 3'b010, 1'b0);
      run_op(2'b10, 2'b10, 32'h8000_0000, 1'b1, 1, 0, 0);
      chk("ovf_inc", 32'(ovf_count), 32'(c + 8'd1));
      // Unsigned carry-out
      set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1);
      run_op(2'b01, 2'b01, 32'd0, 1'b1, 1, 0, 0);
      chk("ovf_inc_unsig", 32'(ovf_count), 32'(c + 8'd2));
      // Subtract without overflow leaves the counter alone
      set_req(0, 32'd100, 32'd1, 3'b000, 1'b0);
      run_op(2'b01, 2'b01, 32'd99, 1'b0, 1, 0, 0);
      chk("ovf_hold", 32'(ovf_count), 32'(c + 8'd2));
    end

    // Multiply: 3-cycle execute, consumer stalls for 5 cycles
    set_req(0, 32'd6, 32'd7, 3'b111, 1'b0);
    run_op(2'b01, 2'b01, 32'd42, 1'b0, 3, 5, 0);
    set_req(1, 32'hFFFF_FFFD, 32'd5, 3'b111, 1'b0);
    run_op(2'b10, 2'b10, 32'hFFFF_FFF1, 1'b0, 3, 0, 0);

    // Reset in the second EXEC cycle of a multiply
    set_req(0, 32'd6, 32'd7, 3'b111, 1'b0);
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    @(negedge clock);
    chk("abort_grant", 32'(req_ready), 32'd1);
    @(posedge clock); #1;           // handshake edge
    req_valid = 2'b00;
    @(posedge clock); #1;           // now in the second EXEC cycle
    reset = 1'b0;
    req_valid = 2'b11;
    @(negedge clock);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_ovf_count", 32'(ovf_count), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    repeat (5) begin
      @(negedge clock);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clock); #1;
    set_req(0, 32'd5, 32'd3, 3'b010, 1'b0);
    set_req(1, 32'd10, 32'd20, 3'b010, 1'b0);
    run_op(2'b11, 2'b01, 32'd8, 1'b0, 1, 0, 0);

    // Saturation of the overflow counter
    do_reset();
    set_req(1, 32'h7FFF_FFFF, 32'd1, 3'b010, 1'b0);
    for (int i = 0; i < 260; i++) begin
      run_op(2'b10, 2'b10, 32'h8000_0000, 1'b1, 1, 0, 0);
      if (i == 0)   chk("sat_first", 32'(ovf_count), 32'd1);
      if (i == 254) chk("sat_reach", 32'(ovf_count), 32'hFF);
    end
    chk("sat_hold", 32'(ovf_count), 32'hFF);

    repeat (2) @(posedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
